matrix_mem_responder: RTL and testbench
=======================================

# matrix_mem_responder

Single-port word-addressed scratchpad memory that serves as the responder end of the `mem_operation`/`mem_opdone` request protocol used by the matrix accelerators. It accepts one read or write request at a time, completes it after a fixed, parameterised latency, and signals completion with a one-cycle `mem_opdone` pulse. Its layout matches what the accelerators expect: words 0..3 hold operand dimensions, and operands and results follow.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: number of implemented address bits; depth is 2^ADDR_WIDTH 32-bit words.
- `READ_LATENCY`, default 2: cycles from request acceptance to the `mem_opdone` pulse for reads; must be ≥1.
- `WRITE_LATENCY`, default 1: the same for writes; must be ≥1.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `mem_operation` in 2: request opcode. 01 is read, 11 is write, 00 is none, 10 is reserved.
- `addr_i` in 32: word address.
- `data_i` in 32: write data.
- `data_o` out 32: read data.
- `mem_opdone` out 1: completion pulse.
- `busy` out 1: high while a request is accepted and not yet completed.
- `err` out 1: sticky error flag.

## Operation

- The state machine has three states: IDLE, WAIT and DONE.
- IDLE:
  - If `mem_operation` ≠ 00, accept the request. This latches `addr_i`, the opcode and `data_i`, and loads the latency counter with LAT−1, where LAT is the read or write latency.
  - Go to DONE if LAT = 1; otherwise go to WAIT.
- WAIT: decrement the counter. When it reaches 0, go to DONE.
- Entry into DONE:
  - Read: register `data_o` from the array at the latched address.
  - Write: commit the latched data to the array on the same edge.
- DONE: `mem_opdone` = 1 for exactly this one cycle, then go to IDLE unconditionally.
- IDLE after DONE never accepts in the DONE cycle itself, so `mem_opdone` is never high on two consecutive cycles. An initiator that holds `mem_operation` = 01 and advances `addr_i` on each `mem_opdone` gets each address served exactly once.
- Out-of-range address (any bit of `addr_i[31:ADDR_WIDTH]` set):
  - A read returns 32'hDEAD_BEEF.
  - A write is dropped.
  - The request still completes normally, and `err` is set.
- Reserved opcode 10: completes with write latency and has no array effect; sets `err`.
- `data_o` holds the last read value until the next read completes. Writes do not disturb it.
- `busy` = 1 in WAIT and DONE, and 0 in IDLE.
- Memory contents are not initialised and are unaffected by `reset`.

## Timing

- Reset values: `data_o` = 0, `mem_opdone` = 0, `busy` = 0, `err` = 0, state = IDLE, counter = 0.
- A request first visible in IDLE in cycle T produces `mem_opdone` = 1 in cycle T+LAT, with `data_o` valid in that same cycle.
- The earliest next acceptance is cycle T+LAT+1, which gives a throughput of one request per LAT+1 cycles.
- Request inputs are sampled only in the accept cycle. Changes to them during WAIT or DONE are ignored.
- Reset asserted during WAIT: the request is abandoned, no write is committed, and there is no `mem_opdone`.
- Reset asserted in the DONE cycle: the commit already happened on entry. `mem_opdone` drops the following cycle.
- `err` clears only on `reset`.

## Configuration

- Macro `MEMRESP_HOST_PORT_EN`.
- Defined: the block adds a host preload/inspection port.
  - Ports: `host_we` in 1, `host_re` in 1, `host_addr` in ADDR_WIDTH, `host_wdata` in 32, `host_rdata` out 32 (reset 0).
  - Host write: commits on the edge where `host_we` = 1.
  - Host read: `host_rdata` is valid the cycle after `host_re` = 1.
  - Host access has priority. In any cycle with `host_we` or `host_re` high, IDLE does not accept a protocol request; acceptance is deferred one cycle per host cycle.
  - A host write in the same cycle as a protocol write commit wins, and the protocol write is dropped.
- Not defined: none of these ports exist. The array is reachable only through the protocol.

## Test plan

- Write, then read back:
  - With WRITE_LATENCY = 1, write 32'h1234_5678 to address 5: `mem_opdone` is high exactly one cycle, at T+1.
  - With READ_LATENCY = 2, a subsequent read of 5: `data_o` = 32'h1234_5678 in the `mem_opdone` cycle, at T+2.
- Burst-style read: hold `mem_operation` = 01 and step `addr_i` 0→4 on each `mem_opdone` with preloaded values 3, 3, 2, 2, 9 → exactly five pulses, each spaced LAT+1 cycles, returning 3, 3, 2, 2, 9 in order.
- Out-of-range address:
  - Read address 32'h0000_1000 with ADDR_WIDTH = 8 → `data_o` = 32'hDEAD_BEEF and `err` = 1.
  - A following write to 32'h0000_1000 is dropped: address 0 is unchanged, and `err` stays 1.
- Reset mid-write: with WRITE_LATENCY = 3, accept a write of 32'hAAAA_AAAA to address 7, then assert reset in the WAIT state → no `mem_opdone`, address 7 retains its old value, and all outputs return to their reset values.
- Reserved opcode: `mem_operation` = 10 → `mem_opdone` after WRITE_LATENCY cycles, no array change, `err` = 1.
- With `MEMRESP_HOST_PORT_EN` defined:
  - A host write of 32'h5 to address 2 in the same cycle as a protocol read request of address 2 → acceptance is delayed one cycle.
  - The read then returns 32'h5.

Source files
------------

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder
// Single-port word-addressed scratchpad that answers the mem_operation /
// mem_opdone request protocol. One request is in flight at a time; it
// completes after READ_LATENCY or WRITE_LATENCY cycles with a one-cycle
// mem_opdone pulse.
// Optional feature macro: MEMRESP_HOST_PORT_EN adds a host preload/inspection
// port that has priority over protocol traffic.
module matrix_mem_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_operation,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  mem_opdone,
  output logic                  busy,
  output logic                  err
`ifdef MEMRESP_HOST_PORT_EN
  ,
  input  logic                  host_we,
  input  logic                  host_re,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata
`endif
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int DEPTH   = 1 << ADDR_WIDTH;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        op_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       mem [DEPTH];

  logic              host_active;
  logic              accept;
  logic [1:0]        eff_op;
  logic [31:0]       eff_addr;
  logic [31:0]       eff_data;
  logic [ADDR_WIDTH-1:0] eff_idx;
  logic              eff_oor;
  logic [CNT_W-1:0]  req_load;
  logic              enter_done;
  logic              commit;

`ifdef MEMRESP_HOST_PORT_EN
  assign host_active = host_we | host_re;
`else
  assign host_active = 1'b0;
`endif

  // A request is taken only from IDLE and only when the host is not using the array.
  assign accept = (state_q == IDLE) && (mem_operation != OP_NONE) && !host_active;

  // With a latency of one, DONE is entered straight from IDLE, so the live
  // request inputs stand in for the not-yet-latched copies.
  assign eff_op   = (state_q == IDLE) ? mem_operation : op_q;
  assign eff_addr = (state_q == IDLE) ? addr_i        : addr_q;
  assign eff_data = (state_q == IDLE) ? data_i        : data_q;
  assign eff_idx  = eff_addr[ADDR_WIDTH-1:0];
  assign req_load = (mem_operation == OP_READ) ? RD_LOAD : WR_LOAD;

  generate
    if (ADDR_WIDTH < 32) begin : g_oor
      assign eff_oor = |eff_addr[31:ADDR_WIDTH];
    end else begin : g_no_oor
      assign eff_oor = 1'b0;
    end
  endgenerate

  // Reset wins over completion, so an abandoned request never commits.
  assign enter_done = (state_d == DONE) && (state_q != DONE) && !reset;
  assign commit     = enter_done && (eff_op == OP_WRITE) && !eff_oor;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept, count down the latency, pulse once, return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (req_load == '0) ? DONE : WAIT;
      WAIT: if (cnt_q <= CNT_ONE) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_opdone = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  // Request latch, latency counter, read data register and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_NONE;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      data_o <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= mem_operation;
        addr_q <= addr_i;
        data_q <= data_i;
        cnt_q  <= req_load;
      end else if (state_q == WAIT) begin
        cnt_q  <= cnt_q - CNT_ONE;
      end
      if (enter_done && (eff_op == OP_READ))
        data_o <= eff_oor ? OOR_DATA : mem[eff_idx];
      if (enter_done && ((eff_op == OP_RSVD) || eff_oor))
        err <= 1'b1;
    end
  end

`ifdef MEMRESP_HOST_PORT_EN
  // Array write port; a host write in the same cycle displaces the protocol write.
  always_ff @(posedge clk) begin
    if (host_we)     mem[host_addr] <= host_wdata;
    else if (commit) mem[eff_idx]   <= eff_data;
  end

  // Host inspection read, registered one cycle after host_re.
  always_ff @(posedge clk) begin
    if (reset)        host_rdata <= '0;
    else if (host_re) host_rdata <= mem[host_addr];
  end
`else
  // Array write port, reachable only through the protocol.
  always_ff @(posedge clk) begin
    if (commit) mem[eff_idx] <= eff_data;
  end
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb_matrix_mem_responder
// Two responder instances: "a" with default latencies (read 2, write 1) and
// "b" with write latency 3 for the mid-write reset scenario. Expected read
// data is queued when a request is issued and popped at mem_opdone.
module tb_matrix_mem_responder;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  logic        clk;
  logic        a_reset, b_reset;
  logic [1:0]  a_op, b_op;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_done, b_done, a_busy, b_busy, a_err, b_err;
`ifdef MEMRESP_HOST_PORT_EN
  logic        a_host_we, a_host_re, b_host_we, b_host_re;
  logic [7:0]  a_host_addr, b_host_addr;
  logic [31:0] a_host_wdata, b_host_wdata, a_host_rdata, b_host_rdata;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  matrix_mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut_a (
    .clk(clk), .reset(a_reset), .mem_operation(a_op), .addr_i(a_addr), .data_i(a_wdata),
    .data_o(a_rdata), .mem_opdone(a_done), .busy(a_busy), .err(a_err)
`ifdef MEMRESP_HOST_PORT_EN
    , .host_we(a_host_we), .host_re(a_host_re), .host_addr(a_host_addr),
    .host_wdata(a_host_wdata), .host_rdata(a_host_rdata)
`endif
  );

  matrix_mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_LATENCY(3)) dut_b (
    .clk(clk), .reset(b_reset), .mem_operation(b_op), .addr_i(b_addr), .data_i(b_wdata),
    .data_o(b_rdata), .mem_opdone(b_done), .busy(b_busy), .err(b_err)
`ifdef MEMRESP_HOST_PORT_EN
    , .host_we(b_host_we), .host_re(b_host_re), .host_addr(b_host_addr),
    .host_wdata(b_host_wdata), .host_rdata(b_host_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request on instance a (sel=0) or b (sel=1), one idle cycle
  // after the call; returns cycles to mem_opdone (-1 on timeout), data_o and err.
  task automatic do_req(input bit sel, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output int lat,
                        output logic [31:0] rd, output logic er);
    bit got;
    @(posedge clk); #1;
    if (sel) begin b_op = op; b_addr = addr; b_wdata = data; end
    else     begin a_op = op; a_addr = addr; a_wdata = data; end
    lat = 0;
    got = 0;
    while (!got && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? b_busy : a_busy) begin
        if (sel) b_op = OP_NONE; else a_op = OP_NONE;
      end
      if (sel ? b_done : a_done) got = 1;
    end
    if (!got) begin
      lat = -1;
      if (sel) b_op = OP_NONE; else a_op = OP_NONE;
    end
    rd = sel ? b_rdata : a_rdata;
    er = sel ? b_err : a_err;
  endtask

  task automatic test_reset();
    a_reset = 1; b_reset = 1;
    a_op = OP_NONE; b_op = OP_NONE;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
`ifdef MEMRESP_HOST_PORT_EN
    a_host_we = 0; a_host_re = 0; a_host_addr = 0; a_host_wdata = 0;
    b_host_we = 0; b_host_re = 0; b_host_addr = 0; b_host_wdata = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_o: got %h expected %h", a_rdata, 32'h0); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_opdone: got %b expected 0", a_done); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end
    total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", a_err); end
    a_reset = 0; b_reset = 0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er; logic [31:0] e;
    do_req(0, OP_WRITE, 32'd5, 32'h1234_5678, lat, rd, er);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL write_latency: got %0d expected 1", lat); end
    @(posedge clk); #1;
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL write_pulse_width: opdone got %b expected 0", a_done); end
    exp_q.push_back(32'h1234_5678);
    do_req(0, OP_READ, 32'd5, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL read_latency: got %0d expected 2", lat); end
    total++; if (rd !== e) begin bad++; $display("[TB] FAIL read_back: got %h expected %h", rd, e); end
    @(posedge clk); #1;
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL read_pulse_width: opdone got %b expected 0", a_done); end
  endtask

  task automatic test_burst();
    int lat; logic [31:0] rd; logic er; logic [31:0] e;
    logic [31:0] vals [5];
    int n, last;
    vals[0] = 32'd3; vals[1] = 32'd3; vals[2] = 32'd2; vals[3] = 32'd2; vals[4] = 32'd9;
    for (int i = 0; i < 5; i++) do_req(0, OP_WRITE, i, vals[i], lat, rd, er);
    for (int i = 0; i < 5; i++) exp_q.push_back(vals[i]);
    @(posedge clk); #1;
    a_op = OP_READ; a_addr = 0;
    n = 0; last = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (a_done) begin
        n++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++; if (a_rdata !== e) begin bad++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", n - 1, a_rdata, e); end
        end
        if (n > 1) begin
          total++; if (cyc - last !== 3) begin bad++; $display("[TB] FAIL burst_spacing[%0d]: got %0d expected 3", n - 1, cyc - last); end
        end
        last = cyc;
        if (n < 5) a_addr = n;
        else a_op = OP_NONE;
      end
    end
    a_op = OP_NONE;
    exp_q.delete();
    total++; if (n !== 5) begin bad++; $display("[TB] FAIL burst_pulse_count: got %0d expected 5", n); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er; logic [31:0] e;
    do_req(0, OP_WRITE, 32'd0, 32'hCAFE_0000, lat, rd, er);
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL inrange_err: got %b expected 0", er); end
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(0, OP_READ, 32'h0000_1000, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("[TB] FAIL oor_read_data: got %h expected %h", rd, e); end
    total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL oor_read_err: got %b expected 1", er); end
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL oor_read_latency: got %0d expected 2", lat); end
    do_req(0, OP_WRITE, 32'h0000_1000, 32'h1111_1111, lat, rd, er);
    total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL oor_write_err: got %b expected 1", er); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL data_o_hold_on_write: got %h expected %h", rd, 32'hDEAD_BEEF); end
    exp_q.push_back(32'hCAFE_0000);
    do_req(0, OP_READ, 32'd0, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("[TB] FAIL oor_write_dropped: addr0 got %h expected %h", rd, e); end
  endtask

  task automatic test_reserved();
    int lat; logic [31:0] rd; logic er; logic [31:0] e;
    @(posedge clk); #1; a_reset = 1;
    @(posedge clk); #1; a_reset = 0;
    total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared_by_reset: got %b expected 0", a_err); end
    do_req(0, OP_WRITE, 32'd9, 32'h0BAD_F00D, lat, rd, er);
    do_req(0, OP_RSVD, 32'd9, 32'h1212_1212, lat, rd, er);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL rsvd_latency: got %0d expected 1", lat); end
    total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL rsvd_err: got %b expected 1", er); end
    exp_q.push_back(32'h0BAD_F00D);
    do_req(0, OP_READ, 32'd9, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("[TB] FAIL rsvd_no_array_change: got %h expected %h", rd, e); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd; logic er; logic [31:0] e;
    int pulses;
    do_req(1, OP_WRITE, 32'd7, 32'h0101_0101, lat, rd, er);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL b_write_latency: got %0d expected 3", lat); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_op = OP_WRITE; b_addr = 32'd7; b_wdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    b_op = OP_NONE;
    total++; if (b_busy !== 1'b1) begin bad++; $display("[TB] FAIL b_accepted: busy got %b expected 1", b_busy); end
    b_reset = 1;
    @(posedge clk); #1;
    b_reset = 0;
    total++; if (b_busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", b_busy); end
    total++; if (b_done !== 1'b0) begin bad++; $display("[TB] FAIL midreset_opdone: got %b expected 0", b_done); end
    total++; if (b_rdata !== 32'h0) begin bad++; $display("[TB] FAIL midreset_data_o: got %h expected %h", b_rdata, 32'h0); end
    total++; if (b_err !== 1'b0) begin bad++; $display("[TB] FAIL midreset_err: got %b expected 0", b_err); end
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b_done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL midreset_no_opdone: got %0d pulses expected 0", pulses); end
    exp_q.push_back(32'h0101_0101);
    do_req(1, OP_READ, 32'd7, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("[TB] FAIL midreset_no_commit: got %h expected %h", rd, e); end
  endtask

`ifdef MEMRESP_HOST_PORT_EN
  task automatic test_host_port();
    logic [31:0] e;
    int t0, lat;
    bit got;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_host_we = 1; a_host_addr = 8'd2; a_host_wdata = 32'h5;
    a_op = OP_READ; a_addr = 32'd2;
    exp_q.push_back(32'h5);
    t0 = cyc;
    @(posedge clk); #1;
    a_host_we = 0;
    total++; if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL host_defers_accept: busy got %b expected 0", a_busy); end
    got = 0;
    repeat (20) begin
      if (!got) begin
        @(posedge clk); #1;
        if (a_busy) a_op = OP_NONE;
        if (a_done) got = 1;
      end
    end
    a_op = OP_NONE;
    lat = got ? (cyc - t0) : -1;
    e = exp_q.pop_front();
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL host_deferred_latency: got %0d expected 3", lat); end
    total++; if (a_rdata !== e) begin bad++; $display("[TB] FAIL host_write_visible: got %h expected %h", a_rdata, e); end
    a_host_re = 1; a_host_addr = 8'd2;
    @(posedge clk); #1;
    a_host_re = 0;
    total++; if (a_host_rdata !== 32'h5) begin bad++; $display("[TB] FAIL host_read: got %h expected %h", a_host_rdata, 32'h5); end
  endtask
`endif

  initial begin
    $display("[TB] starting matrix_mem_responder bench");
    test_reset();
    test_write_read();
    test_burst();
    test_out_of_range();
    test_reserved();
    test_reset_mid_write();
`ifdef MEMRESP_HOST_PORT_EN
    test_host_port();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
